// File: rtl/fetch_queue.sv
// Pipelined fetch front end: owns the PC, issues one instruction-memory read per
// cycle and buffers returned {pc, instr} pairs in a DEPTH-entry queue for decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000,
  parameter int              DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]    pc_reg;
  logic [XLEN-1:0]    resp_pc_reg;
  logic               inflight_reg;
  logic [CW-1:0]      count_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [PW-1:0]      wr_ptr_reg;

  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [CW:0]        occupancy;
  logic               issue;
  logic               push;
  logic               pop;
  logic [XLEN-1:0]    target_pc;

  // Counting the in-flight slot as occupied guarantees the response always has room.
  assign occupancy = {1'b0, count_reg} + (CW + 1)'(inflight_reg);
  assign issue     = !reset && !redirect_valid && (occupancy < DEPTH_W);
  assign push      = inflight_reg && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign target_pc = redirect_pc & ~XLEN'(3);

  assign imem_req  = issue;
  assign imem_addr = pc_reg;
  assign out_valid = !reset && (count_reg != '0);
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign out_instr = instr_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      resp_pc_reg  <= '0;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else if (redirect_valid) begin
      // Flush: the queued entries and the arriving response are both stale.
      pc_reg       <= target_pc;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg      <= pc_reg + XLEN'(4);
        resp_pc_reg <= pc_reg;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized redirect/ready/reset traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int tests = 0;
  int fails = 0;

  // Reference model: expected queue contents, outstanding request, next fetch PC.
  logic [63:0] mq[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_addr = '0;
  logic [31:0] m_pc = RST_PC;

  fetch_queue #(.XLEN(32), .INSTR_W(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory answers one cycle after a request; junk otherwise so stray pushes show.
  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : $urandom();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic exp_req, exp_valid;
    logic [63:0] head;
    @(negedge clk);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
    exp_req   = !rst && !rv && ((mq.size() + int'(m_pend)) < DEPTH);
    exp_valid = !rst && (mq.size() != 0);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = mq[0];
      chk("out_pc", out_pc, head[63:32]);
      chk("out_instr", out_instr, head[31:0]);
    end
    if (rst) begin
      mq.delete(); m_pend = 1'b0; m_pc = RST_PC;
    end else if (rv) begin
      mq.delete(); m_pend = 1'b0; m_pc = rpc & ~32'h3;
    end else begin
      if (exp_valid && rdy) void'(mq.pop_front());
      if (m_pend) mq.push_back({m_pend_addr, memf(m_pend_addr)});
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_addr = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Hold ready low until the queue has 3 entries plus one in flight.
  task automatic fill_to_three();
    int n = 0;
    while (!(mq.size() == 3 && m_pend) && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("fill_timeout", 32'(n < 20), 32'd1);
  endtask

  initial begin
    // 1: reset release, sequential stream
    step(1, 0, 0, 1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_req", 32'(imem_req), 32'd0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("c0_addr", imem_addr, 32'h0100_0000);
    step(0, 0, 0, 1);
    chk("c1_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("c2_valid", 32'(out_valid), 32'd1);
    chk("c2_pc", out_pc, 32'h0100_0000);
    step(0, 0, 0, 1);
    chk("c3_pc", out_pc, 32'h0100_0004);
    step(0, 0, 0, 1);
    chk("c4_pc", out_pc, 32'h0100_0008);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // 2: stall decode until full, then drain
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);

    // 3: redirect with 3 queued and one in flight
    fill_to_three();
    step(0, 1, 32'h0100_0040, 0);
    step(0, 0, 0, 1);
    chk("r1_valid", 32'(out_valid), 32'd0);
    chk("r1_addr", imem_addr, 32'h0100_0040);
    step(0, 0, 0, 1);
    chk("r2_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("r3_pc", out_pc, 32'h0100_0040);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // 4: redirect colliding with a pop, unaligned target
    chk("pre4_valid", 32'(out_valid), 32'd1);
    step(0, 1, 32'h0100_0042, 1);
    step(0, 0, 0, 1);
    chk("t4_addr", imem_addr, 32'h0100_0040);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t4_pc", out_pc, 32'h0100_0040);

    // 5: PC wrap
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrap0", out_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap1", out_pc, 32'h0000_0000);
    step(0, 0, 0, 1);
    chk("wrap2", out_pc, 32'h0000_0004);

    // 6: reset mid-operation
    fill_to_three();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst6_valid", 32'(out_valid), 32'd0);
    chk("rst6_req", 32'(imem_req), 32'd1);
    chk("rst6_addr", imem_addr, 32'h0100_0000);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rst, rv, rdy;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : (32'h0100_0000 | 32'($urandom_range(0, 1023)));
      step(rst, rv, rpc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
